i2c_target_regs: RTL and testbench
==================================

// Module: i2c_target_regs
// PURPOSE
//  I2C target (responder) exposing a byte-addressed register space to an external I2C controller.
//  It is the bus-side counterpart of our EEPROM/ID-readout controller.
//  Sits behind SB_IO open-drain pads (SDA/SCL inputs, SDA pull-low enable). Bridges bus transfers to a
//  simple synchronous register port, with no clock stretching.
// PARAMETERS
//  DEV_ADDR    7'h50  7-bit target address matched after START
//  PTR_W       8      register pointer width; register space is 2**PTR_W bytes
//  FILTER_LEN  3      consecutive equal clk samples required to accept a new SCL/SDA level
// PORTS
//  clk        in   1      system clock (16 MHz); only clock
//  reset_n    in   1      asynchronous, active-low reset
//  scl_in     in   1      raw SCL pad input
//  sda_in     in   1      raw SDA pad input
//  sda_oe     out  1      1 = pull SDA low (drives SB_IO OUTPUT_ENABLE; D_OUT tied 0)
//  reg_addr   out  PTR_W  current register pointer
//  reg_wdata  out  8      write data, valid while reg_we=1
//  reg_we     out  1      one-clk write strobe
//  reg_rdata  in   8      read data for reg_addr; host returns it combinationally or registered, valid <=1 clk after reg_addr changes
//  busy       out  1      1 between START addressed to us and following STOP/START
// BEHAVIOUR
//  Reset: sda_oe=0, reg_we=0, reg_addr=0, reg_wdata=0, busy=0. Sync/filter flops reset to 1 (idle bus).
//   State=IDLE. Reset mid-transfer releases SDA immediately.
//  Input path: 2-FF synchroniser per line, then a filter. Filtered level changes only after FILTER_LEN equal samples.
//   Edges are detected on filtered levels (1 clk pulses).
//  START: SDA fall while SCL=1. STOP: SDA rise while SCL=1. Both are honoured in every state:
//   - abort the current byte (partial byte discarded, no reg_we);
//   - sda_oe=0 within 1 clk.
//   START -> ADDR; STOP -> IDLE, busy=0. A repeated START keeps the pointer.
//  Bits are sampled on SCL rise, MSB first. sda_oe changes only on SCL fall (+1 clk).
//  FSM: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
//   ADDR: 8 bits. [7:1]!=DEV_ADDR -> IDLE (no ACK, ignore until next START).
//   On match: busy=1 -> ADDR_ACK, sda_oe=1 for the 9th clock.
//   After ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA.
//     Entering RDATA, at the ACK SCL fall latch reg_rdata into the tx shifter, then reg_addr<=reg_addr+1.
//   PTR: 8 bits; reg_addr<=byte[PTR_W-1:0]; ACK -> WDATA.
//   WDATA: 8 bits. On 8th SCL rise: reg_wdata<=byte, reg_we pulses 1 clk at reg_addr.
//     Then ACK; pointer increments on the ACK SCL fall -> WDATA.
//   RDATA: drive shifter MSB first (sda_oe = ~bit) on SCL falls.
//     After the 8th bit release SDA -> RDATA_ACK.
//   RDATA_ACK: sample controller ACK on SCL rise.
//     ACK(0): latch reg_rdata, increment pointer -> RDATA.
//     NACK(1): release, wait for STOP/START (state IDLE, busy held until STOP).
//  Pointer arithmetic is modulo 2**PTR_W: 0xFF+1 -> 0x00 for PTR_W=8.
//   Only the low PTR_W bits of the pointer byte are used.
//  reg_we and a START/STOP in the same clk: STOP/START wins and the write is suppressed.
//  SDA sampled high while we drive low (we never release early): no arbitration, no error output.
//  Latency: ACK asserted by the first clk after the 8th-bit SCL fall + filter delay (FILTER_LEN+2 clk from pad).
//   Limits SCL to <=400 kHz at 16 MHz.
// STRUCTURE
//  Shared package/header: state encodings; I2C_RW_READ=1; ACK=0/NACK=1 constants.
//  One sub-module: i2c_line_filter (2-FF sync + FILTER_LEN glitch filter + rise/fall pulses), instanced for SCL and SDA.
//  FSM, bit counter (0..8), shift registers and pointer are in this file.
// TESTING
//  1 Write 0xA0,0x10,0x55,0xAA,STOP
//    -> ACK on all 4 bytes; reg_we pulses twice: (0x10,0x55), (0x11,0xAA); busy 0 after STOP.
//  2 Write 0xA0,0x20; repeated START; 0xA1; read 3 bytes, ACK,ACK,NACK; host model rdata=addr^0x5A
//    -> bus returns 0x7A,0x7B,0x78; final reg_addr=0x23.
//  3 Address 0xA2 (mismatch) with data 0x00,0x11
//    -> sda_oe stays 0 whole transfer; no reg_we; busy=0.
//  4 Pointer 0xFF, write 0x01,0x02
//    -> writes at 0xFF then 0x00 (wrap).
//  5 STOP injected after 4 bits of a WDATA byte
//    -> no reg_we; next START+0xA0 ACKed normally.
//  6 SCL/SDA glitches of FILTER_LEN-1 clk during idle and mid-byte
//    -> no START/STOP or bit detected. Also assert reset_n mid-read: sda_oe=0 and all outputs at reset values within 1 clk.

Source files
------------

// File: rtl/i2c_target_regs_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_target_regs_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 4;

    localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = BIT_CNT_W'(8);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT      = BIT_CNT_W'(7);

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_state_t;

    // MSB-first shift of one received bit into a byte
    function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] v, input logic b);
        return {v[BYTE_W-2:0], b};
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus glitch filter for one I2C line; emits 1-clk edge pulses
// aligned with the filtered level change.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0]            sync_q;
    logic [FILTER_LEN-2:0] hist_q;
    logic [FILTER_LEN-1:0] hist_c;
    logic                  all_high_c;
    logic                  all_low_c;

    // Current synchronised sample plus the previous FILTER_LEN-1 samples
    assign hist_c     = {hist_q, sync_q[1]};
    assign all_high_c = &hist_c;
    assign all_low_c  = ~|hist_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            hist_q <= '1;
            level  <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_in};
            hist_q <= hist_c[FILTER_LEN-2:0];
            rise   <= all_high_c & ~level;
            fall   <= all_low_c & level;
            if (all_high_c) begin
                level <= 1'b1;
            end else if (all_low_c) begin
                level <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target bridging bus transfers to a byte-addressed synchronous register port.
// No clock stretching; SDA is only ever pulled low.
module i2c_target_regs
    import i2c_target_regs_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR   = 7'h50,
    parameter int unsigned PTR_W      = 8,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic [PTR_W-1:0] reg_addr,
    output logic [7:0]       reg_wdata,
    output logic             reg_we,
    input  logic [7:0]       reg_rdata,
    output logic             busy
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .reset_n(reset_n), .line_in(scl_in),
        .level(scl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .reset_n(reset_n), .line_in(sda_in),
        .level(sda), .rise(sda_rise), .fall(sda_fall)
    );

    i2c_state_t           state, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_d;
    logic [BYTE_W-1:0]    shift_rx, shift_rx_d;
    logic [BYTE_W-1:0]    shift_tx, shift_tx_d;
    logic [PTR_W-1:0]     reg_addr_d;
    logic [7:0]           reg_wdata_d;
    logic                 reg_we_d, sda_oe_d, busy_d;

    logic                 start_c, stop_c, byte_done_c, addr_match_c;
    logic [BYTE_W-1:0]    rx_byte_c;

    assign start_c      = sda_fall & scl;
    assign stop_c       = sda_rise & scl;
    assign byte_done_c  = (bit_cnt == BITS_PER_BYTE);
    assign addr_match_c = (shift_rx[7:1] == DEV_ADDR);
    assign rx_byte_c    = shift_in(shift_rx, sda);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Bus conditions override every state; otherwise byte boundaries move on SCL edges
    always_comb begin
        state_d = state;
        if (start_c) begin
            state_d = ST_ADDR;
        end else if (stop_c) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_ADDR:      if (scl_fall && byte_done_c) state_d = addr_match_c ? ST_ADDR_ACK : ST_IDLE;
                ST_ADDR_ACK:  if (scl_fall) state_d = (shift_rx[0] == I2C_RW_READ) ? ST_RDATA : ST_PTR;
                ST_PTR:       if (scl_fall && byte_done_c) state_d = ST_PTR_ACK;
                ST_PTR_ACK:   if (scl_fall) state_d = ST_WDATA;
                ST_WDATA:     if (scl_fall && byte_done_c) state_d = ST_WDATA_ACK;
                ST_WDATA_ACK: if (scl_fall) state_d = ST_WDATA;
                ST_RDATA:     if (scl_fall && byte_done_c) state_d = ST_RDATA_ACK;
                ST_RDATA_ACK: if (scl_rise) state_d = (sda == I2C_NACK) ? ST_IDLE : ST_RDATA;
                default:      state_d = state;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d   = bit_cnt;
        shift_rx_d  = shift_rx;
        shift_tx_d  = shift_tx;
        reg_addr_d  = reg_addr;
        reg_wdata_d = reg_wdata;
        reg_we_d    = 1'b0;
        sda_oe_d    = sda_oe;
        busy_d      = busy;
        if (start_c || stop_c) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && !byte_done_c) begin
                        shift_rx_d = rx_byte_c;
                        bit_cnt_d  = bit_cnt + BIT_CNT_W'(1);
                        if (state == ST_WDATA && bit_cnt == LAST_BIT) begin
                            reg_wdata_d = rx_byte_c;
                            reg_we_d    = 1'b1;
                        end
                    end else if (scl_fall && byte_done_c) begin
                        bit_cnt_d = '0;
                        if (state != ST_ADDR || addr_match_c) sda_oe_d = 1'b1;
                        if (state == ST_ADDR && addr_match_c) busy_d = 1'b1;
                        if (state == ST_PTR) reg_addr_d = shift_rx[PTR_W-1:0];
                    end
                end
                ST_ADDR_ACK: begin
                    // A read drives its first bit on the same fall that ends the ACK
                    if (scl_fall) begin
                        if (shift_rx[0] == I2C_RW_READ) begin
                            shift_tx_d = {reg_rdata[6:0], 1'b0};
                            sda_oe_d   = ~reg_rdata[7];
                            reg_addr_d = reg_addr + PTR_W'(1);
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                end
                ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d   = 1'b0;
                        reg_addr_d = reg_addr + PTR_W'(1);
                    end
                end
                ST_RDATA: begin
                    if (scl_rise && !byte_done_c) begin
                        bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
                    end else if (scl_fall) begin
                        if (byte_done_c) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                        end else begin
                            sda_oe_d   = ~shift_tx[7];
                            shift_tx_d = {shift_tx[6:0], 1'b0};
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise && sda == I2C_ACK) begin
                        shift_tx_d = reg_rdata;
                        reg_addr_d = reg_addr + PTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= '0;
            shift_rx  <= '0;
            shift_tx  <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt_d;
            shift_rx  <= shift_rx_d;
            shift_tx  <= shift_tx_d;
            reg_addr  <= reg_addr_d;
            reg_wdata <= reg_wdata_d;
            reg_we    <= reg_we_d;
            sda_oe    <= sda_oe_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bus-level controller model, open-drain SDA, register host
// model (rdata = addr ^ key) and a pointer/write-log reference model.
module tb_i2c_target_regs;

    localparam int unsigned FILTER_LEN = 3;
    localparam int          Q          = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scl_drv, sda_ctrl, scl_gl, sda_gl;
    logic       scl_in, sda_in, sda_oe, reg_we, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata, rd_key;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] m_ptr;
    logic [7:0] wbuf [4];
    logic [15:0] wq[$];
    logic [15:0] exp_w[$];
    bit         oe_seen;

    always #5 clk = ~clk;

    assign scl_in    = scl_drv ^ scl_gl;
    assign sda_in    = (sda_ctrl & ~sda_oe) ^ sda_gl;
    assign reg_rdata = reg_addr ^ rd_key;

    i2c_target_regs #(.DEV_ADDR(7'h50), .PTR_W(8), .FILTER_LEN(FILTER_LEN)) dut (
        .clk(clk), .reset_n(reset_n), .scl_in(scl_in), .sda_in(sda_in),
        .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_rdata(reg_rdata), .busy(busy)
    );

    always @(negedge clk) begin
        if (reg_we) wq.push_back({reg_addr, reg_wdata});
        if (sda_oe) oe_seen = 1'b1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_scl();
        scl_gl = 1'b1; tick(FILTER_LEN - 1); scl_gl = 1'b0;
    endtask

    task automatic pulse_sda();
        sda_gl = 1'b1; tick(FILTER_LEN - 1); sda_gl = 1'b0;
    endtask

    task automatic bus_start();
        sda_ctrl = 1'b1; tick(Q); scl_drv = 1'b1; tick(Q);
        sda_ctrl = 1'b0; tick(Q); scl_drv = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_ctrl = 1'b0; tick(Q); scl_drv = 1'b1; tick(Q);
        sda_ctrl = 1'b1; tick(2 * Q);
    endtask

    task automatic send_bit(input logic b, input bit gl_scl, input bit gl_sda);
        sda_ctrl = b; tick(Q); scl_drv = 1'b1; tick(Q);
        if (gl_sda) pulse_sda();
        tick(Q); scl_drv = 1'b0; tick(Q / 2);
        if (gl_scl) pulse_scl();
        tick(Q - Q / 2);
    endtask

    task automatic send_bits(input logic [7:0] b, input bit gl);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gl && i == 4, gl && i == 2);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack, input bit gl);
        send_bits(b, gl);
        sda_ctrl = 1'b1; tick(Q); scl_drv = 1'b1; tick(Q);
        ack = sda_in;
        tick(Q); scl_drv = 1'b0; tick(Q);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        for (int i = 7; i >= 0; i--) begin
            sda_ctrl = 1'b1; tick(Q); scl_drv = 1'b1; tick(Q);
            b[i] = sda_in;
            tick(Q); scl_drv = 1'b0; tick(Q);
        end
        sda_ctrl = nack; tick(Q); scl_drv = 1'b1; tick(2 * Q); scl_drv = 1'b0; tick(Q);
    endtask

    task automatic check_writes();
        logic [15:0] g, e;
        check_eq("wr_count", 32'(wq.size()), 32'(exp_w.size()));
        while (exp_w.size() > 0 && wq.size() > 0) begin
            e = exp_w.pop_front();
            g = wq.pop_front();
            check_eq("wr_entry", 32'(g), 32'(e));
        end
        wq.delete();
        exp_w.delete();
    endtask

    // Pointer write followed by n data bytes starting at ptr
    task automatic do_write(input logic [7:0] ptr, input int n, input bit gl);
        logic a;
        bus_start();
        write_byte(8'hA0, a, 1'b0); check_eq("w_addr_ack", 32'(a), 32'(0));
        check_eq("w_busy", 32'(busy), 32'(1));
        write_byte(ptr, a, 1'b0); check_eq("w_ptr_ack", 32'(a), 32'(0));
        m_ptr = ptr;
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], a, gl); check_eq("w_data_ack", 32'(a), 32'(0));
            exp_w.push_back({m_ptr, wbuf[i]});
            m_ptr = m_ptr + 8'd1;
        end
        bus_stop();
        check_eq("w_busy_after_stop", 32'(busy), 32'(0));
        check_writes();
        check_eq("w_ptr", 32'(reg_addr), 32'(m_ptr));
    endtask

    // Optional pointer set + repeated START, then read n bytes, NACKing the last
    task automatic do_read(input int n, input bit set_ptr, input logic [7:0] ptr);
        logic a;
        logic [7:0] b;
        bus_start();
        if (set_ptr) begin
            write_byte(8'hA0, a, 1'b0); check_eq("r_waddr_ack", 32'(a), 32'(0));
            write_byte(ptr, a, 1'b0);   check_eq("r_ptr_ack", 32'(a), 32'(0));
            m_ptr = ptr;
            bus_start();
        end
        write_byte(8'hA1, a, 1'b0); check_eq("r_addr_ack", 32'(a), 32'(0));
        for (int i = 0; i < n; i++) begin
            read_byte(b, (i == n - 1));
            check_eq("r_data", 32'(b), 32'(m_ptr ^ rd_key));
            m_ptr = m_ptr + 8'd1;
        end
        bus_stop();
        check_eq("r_busy_after_stop", 32'(busy), 32'(0));
        check_eq("r_ptr", 32'(reg_addr), 32'(m_ptr));
        check_eq("r_no_writes", 32'(wq.size()), 32'(0));
        wq.delete();
    endtask

    initial begin
        logic a;
        reset_n = 1'b0; scl_drv = 1'b1; sda_ctrl = 1'b1; scl_gl = 1'b0; sda_gl = 1'b0;
        rd_key = 8'h5A; m_ptr = 8'h00; oe_seen = 1'b0;
        tick(5);
        check_eq("rst_sda_oe", 32'(sda_oe), 32'(0));
        check_eq("rst_reg_we", 32'(reg_we), 32'(0));
        check_eq("rst_reg_addr", 32'(reg_addr), 32'(0));
        check_eq("rst_reg_wdata", 32'(reg_wdata), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        reset_n = 1'b1;
        tick(10);

        // Two-byte write from pointer 0x10
        wbuf[0] = 8'h55; wbuf[1] = 8'hAA;
        do_write(8'h10, 2, 1'b0);

        // Pointer 0x20, repeated START, three-byte read
        do_read(3, 1'b1, 8'h20);

        // Foreign address: never acknowledged, never written
        oe_seen = 1'b0;
        bus_start();
        write_byte(8'hA2, a, 1'b0); check_eq("mis_addr_nack", 32'(a), 32'(1));
        check_eq("mis_busy", 32'(busy), 32'(0));
        write_byte(8'h00, a, 1'b0);
        write_byte(8'h11, a, 1'b0);
        bus_stop();
        check_eq("mis_oe_seen", 32'(oe_seen), 32'(0));
        check_eq("mis_no_writes", 32'(wq.size()), 32'(0));
        wq.delete();

        // Pointer wrap at the top of the register space
        wbuf[0] = 8'h01; wbuf[1] = 8'h02;
        do_write(8'hFF, 2, 1'b0);

        // STOP after a partial data byte discards it
        bus_start();
        write_byte(8'hA0, a, 1'b0); check_eq("abort_addr_ack", 32'(a), 32'(0));
        write_byte(8'h40, a, 1'b0); check_eq("abort_ptr_ack", 32'(a), 32'(0));
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
        bus_stop();
        check_eq("abort_no_write", 32'(wq.size()), 32'(0));
        wq.delete();
        wbuf[0] = 8'hC3;
        do_write(8'h41, 1, 1'b0);

        // Short glitches while idle and inside data bytes are filtered out
        pulse_sda(); tick(Q); pulse_scl(); tick(Q);
        check_eq("glitch_idle_busy", 32'(busy), 32'(0));
        check_eq("glitch_idle_no_write", 32'(wq.size()), 32'(0));
        wbuf[0] = 8'h96; wbuf[1] = 8'h3C;
        do_write(8'h30, 2, 1'b1);

        // Reset while acknowledging a read address
        bus_start();
        send_bits(8'hA1, 1'b0);
        sda_ctrl = 1'b1; tick(Q); scl_drv = 1'b1; tick(Q / 2);
        check_eq("pre_rst_oe", 32'(sda_oe), 32'(1));
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_sda_oe", 32'(sda_oe), 32'(0));
        check_eq("mid_rst_busy", 32'(busy), 32'(0));
        check_eq("mid_rst_reg_addr", 32'(reg_addr), 32'(0));
        check_eq("mid_rst_reg_we", 32'(reg_we), 32'(0));
        check_eq("mid_rst_reg_wdata", 32'(reg_wdata), 32'(0));
        tick(3);
        reset_n = 1'b1;
        tick(10);
        m_ptr = 8'h00;
        do_read(2, 1'b0, 8'h00);

        // Randomised mix of writes and reads against the pointer model
        for (int t = 0; t < 10; t++) begin
            int kind, n;
            kind   = int'($urandom_range(0, 2));
            n      = int'($urandom_range(1, 3));
            rd_key = 8'($urandom);
            if (kind == 0) begin
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                do_write(8'($urandom), n, 1'b0);
            end else begin
                do_read(n, (kind == 1), 8'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
